// File: rtl/pcie_egress_reader.sv
// Egress reader/merger: drains four destination FIFOs round-robin onto one registered stream
// through a 2-entry skid buffer, with per-port read counters readable while idle.
module pcie_egress_reader #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [3:0]        empty,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic              ready,
    output logic [3:0]        pop,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        port_out,
    output logic              valid_out,
    input  logic              req,
    input  logic [1:0]        idx,
    output logic [CNT_W-1:0]  cnt_data,
    output logic              cnt_valid,
    output logic              idle_out
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic              infl_q, infl_d;
    logic [1:0]        infl_port_q, infl_port_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_port_q, out_port_d;
    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] sk_data_q, sk_data_d;
    logic [1:0]        sk_port_q, sk_port_d;
    logic              sk_vld_q, sk_vld_d;
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_d [4];
    logic [CNT_W-1:0]  cnt_data_q, cnt_data_d;
    logic              cnt_valid_q, cnt_valid_d;

    logic [DATA_W-1:0] din [4];
    logic              pop_en;
    logic              cons;
    logic [2:0]        load;
    logic              room;
    logic              gnt_vld;
    logic [1:0]        gnt;
    logic              fire;

    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign din[2] = data_in2;
    assign din[3] = data_in3;

    assign data_out  = out_data_q;
    assign port_out  = out_port_q;
    assign valid_out = out_vld_q;
    assign cnt_data  = cnt_data_q;
    assign cnt_valid = cnt_valid_q;

    // Words held or owed to the skid after this cycle's consumption and landing.
    assign cons = out_vld_q & ready;
    assign load = 3'(out_vld_q) + 3'(sk_vld_q) + 3'(infl_q) - 3'(cons);
    assign room = load < 3'd2;

    always_comb begin
        logic [1:0] p;
        gnt_vld = 1'b0;
        gnt     = ptr_q;
        for (int i = 0; i < 4; i++) begin
            p = ptr_q + 2'(i);
            if (!gnt_vld && !empty[p]) begin
                gnt_vld = 1'b1;
                gnt     = p;
            end
        end
    end

    assign fire = pop_en & gnt_vld & room;
    assign pop  = fire ? (4'b0001 << gnt) : 4'b0000;

    always_comb begin
        ptr_d       = fire ? gnt + 2'd1 : ptr_q;
        infl_d      = fire;
        infl_port_d = fire ? gnt : infl_port_q;
    end

    // Skid: out_* is the head and drives the outputs, sk_* backs it up while stalled.
    always_comb begin
        out_data_d = out_data_q;
        out_port_d = out_port_q;
        out_vld_d  = out_vld_q;
        sk_data_d  = sk_data_q;
        sk_port_d  = sk_port_q;
        sk_vld_d   = sk_vld_q;
        if (!out_vld_q || cons) begin
            if (sk_vld_q) begin
                out_data_d = sk_data_q;
                out_port_d = sk_port_q;
                out_vld_d  = 1'b1;
                sk_vld_d   = infl_q;
                if (infl_q) begin
                    sk_data_d = din[infl_port_q];
                    sk_port_d = infl_port_q;
                end
            end else begin
                out_vld_d = infl_q;
                if (infl_q) begin
                    out_data_d = din[infl_port_q];
                    out_port_d = infl_port_q;
                end
            end
        end else if (infl_q) begin
            sk_data_d = din[infl_port_q];
            sk_port_d = infl_port_q;
            sk_vld_d  = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = pop[i] ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
        end
        cnt_valid_d = req && (state_q == IDLE);
        cnt_data_d  = cnt_valid_d ? cnt_q[idx] : cnt_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = ACTIVE;
            ACTIVE:  if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable) state_d = ACTIVE;
                else if (!infl_q && !out_vld_q && !sk_vld_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop_en   = (state_q == ACTIVE);
        idle_out = (state_q == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= 2'd0;
            infl_q      <= 1'b0;
            infl_port_q <= 2'd0;
            out_data_q  <= '0;
            out_port_q  <= 2'd0;
            out_vld_q   <= 1'b0;
            sk_data_q   <= '0;
            sk_port_q   <= 2'd0;
            sk_vld_q    <= 1'b0;
            cnt_data_q  <= '0;
            cnt_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            ptr_q       <= ptr_d;
            infl_q      <= infl_d;
            infl_port_q <= infl_port_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
            out_vld_q   <= out_vld_d;
            sk_data_q   <= sk_data_d;
            sk_port_q   <= sk_port_d;
            sk_vld_q    <= sk_vld_d;
            cnt_data_q  <= cnt_data_d;
            cnt_valid_q <= cnt_valid_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule

// File: tb/tb_pcie_egress_reader.sv
// Randomized bench for pcie_egress_reader: FIFO models, a word-level scoreboard and an
// outstanding-word budget predict pops, output stream and counter reads.
module tb_pcie_egress_reader;
    localparam int DW = 12;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          ready = 1'b0;
    logic          req = 1'b0;
    logic [1:0]    idx = 2'd0;
    logic [3:0]    empty = 4'hF;
    logic [DW-1:0] din [4];
    logic [3:0]    pop;
    logic [DW-1:0] data_out;
    logic [1:0]    port_out;
    logic          valid_out;
    logic [CW-1:0] cnt_data;
    logic          cnt_valid;
    logic          idle_out;

    always #5 clk = ~clk;

    pcie_egress_reader #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .empty(empty),
        .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
        .ready(ready), .pop(pop), .data_out(data_out), .port_out(port_out),
        .valid_out(valid_out), .req(req), .idx(idx), .cnt_data(cnt_data),
        .cnt_valid(cnt_valid), .idle_out(idle_out)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef logic [DW-1:0] wq_t[$];
    typedef struct {
        logic [DW-1:0] d;
        logic [1:0]    p;
        int            cyc;
    } ent_t;

    wq_t  fifo [4];
    ent_t sb[$];
    int   mode;      // 0 idle, 1 active, 2 drain
    int   ptr;
    int   cnt [4];
    bit   pend;
    int   pend_val;
    int   cyc;

    task automatic upd_empty();
        for (int p = 0; p < 4; p++) empty[p] = (fifo[p].size() == 0);
    endtask

    task automatic model_reset();
        sb.delete();
        for (int p = 0; p < 4; p++) cnt[p] = 0;
        mode = 0;
        ptr  = 0;
        pend = 0;
    endtask

    task automatic tick();
        int            gp;
        int            outst;
        int            nmode;
        bit            exp_v;
        bit            cons;
        logic [3:0]    exp_pop;
        logic [DW-1:0] w;
        ent_t          e;
        @(negedge clk);
        outst = sb.size();
        exp_v = (outst > 0) && (sb[0].cyc <= cyc - 2);
        cons  = exp_v && ready;
        gp = -1;
        if (mode == 1 && (outst - int'(cons)) < 2) begin
            for (int i = 0; i < 4; i++) begin
                if (gp < 0 && fifo[(ptr + i) % 4].size() > 0) gp = (ptr + i) % 4;
            end
        end
        exp_pop = (gp >= 0) ? (4'b0001 << gp) : 4'b0000;
        chk("idle_out", 32'(idle_out), 32'(mode == 0));
        chk("pop", 32'(pop), 32'(exp_pop));
        chk("valid_out", 32'(valid_out), 32'(exp_v));
        if (exp_v) begin
            chk("data_out", 32'(data_out), 32'(sb[0].d));
            chk("port_out", 32'(port_out), 32'(sb[0].p));
        end
        chk("cnt_valid", 32'(cnt_valid), 32'(pend));
        if (pend) chk("cnt_data", 32'(cnt_data), 32'(pend_val));

        if (cons) e = sb.pop_front();
        pend     = req && (mode == 0);
        pend_val = cnt[idx];
        nmode = mode;
        case (mode)
            0: if (enable) nmode = 1;
            1: if (!enable) nmode = 2;
            default: if (enable) nmode = 1; else if (outst == 0) nmode = 0;
        endcase
        w = '0;
        if (gp >= 0) begin
            w = fifo[gp].pop_front();
            e.d = w; e.p = 2'(gp); e.cyc = cyc;
            sb.push_back(e);
            cnt[gp] = (cnt[gp] + 1) % 32;
            ptr = (gp + 1) % 4;
        end
        @(posedge clk);
        #1;
        if (gp >= 0) din[gp] = w;
        mode = nmode;
        cyc++;
        upd_empty();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (mode != 0 && n < budget) begin
            tick();
            n++;
        end
        if (mode != 0) chk("drain_timeout", 32'(mode), 32'd0);
    endtask

    initial begin
        for (int p = 0; p < 4; p++) din[p] = '0;
        model_reset();
        cyc = 0;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_idle", 32'(idle_out), 32'd1);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_cnt_valid", 32'(cnt_valid), 32'd0);
        chk("rst_cnt_data", 32'(cnt_data), 32'd0);
        reset = 1'b1;
        repeat (3) tick();

        ready = 1'b1;
        fifo[2].push_back(12'h2A1);
        fifo[2].push_back(12'h2A2);
        fifo[2].push_back(12'h2A3);
        upd_empty();
        repeat (8) tick();

        fifo[3].push_back(12'($urandom));
        upd_empty();
        repeat (5) tick();

        for (int p = 0; p < 4; p++)
            repeat (3) fifo[p].push_back(12'($urandom));
        upd_empty();
        repeat (4) tick();
        ready = 1'b0;
        repeat (5) tick();
        ready = 1'b1;
        repeat (15) tick();

        repeat (300) begin
            if ($urandom_range(0, 2) == 0) fifo[$urandom_range(0, 3)].push_back(12'($urandom));
            ready  = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 15) != 0);
            req    = ($urandom_range(0, 5) == 0);
            idx    = 2'($urandom);
            upd_empty();
            tick();
        end
        enable = 1'b1;
        ready  = 1'b1;
        req    = 1'b0;
        repeat (60) tick();

        repeat (4) fifo[1].push_back(12'($urandom));
        upd_empty();
        repeat (2) tick();
        enable = 1'b0;
        wait_idle(50);
        req = 1'b1;
        idx = 2'd1;
        tick();
        req = 1'b0;
        repeat (2) tick();

        enable = 1'b1;
        repeat (8) fifo[0].push_back(12'($urandom));
        upd_empty();
        repeat (4) tick();
        reset = 1'b0;
        #1;
        chk("midrst_pop", 32'(pop), 32'd0);
        chk("midrst_valid", 32'(valid_out), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int p = 0; p < 4; p++) fifo[p].delete();
        repeat (33) fifo[0].push_back(12'($urandom));
        upd_empty();
        for (int n = 0; n < 60 && (fifo[0].size() > 0 || sb.size() > 0); n++) tick();
        if (fifo[0].size() > 0) chk("wrap_timeout", 32'(fifo[0].size()), 32'd0);
        enable = 1'b0;
        wait_idle(20);
        req = 1'b1;
        idx = 2'd0;
        tick();
        req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
